// File: rtl/ram_mp_bank.sv
// Multi-read-port word RAM with byte-enabled write, pipelined reads, range checks
// and a post-reset clear sequencer that zeroes the array one word per cycle.
module ram_mp_bank #(
  parameter int D_WIDTH    = 32,
  parameter int A_WIDTH    = 5,
  parameter int DEPTH      = 32,
  parameter int RD_PORTS   = 2,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_busy,
  output logic                          state_dbg,
  input  logic                          write_en,
  input  logic [A_WIDTH-1:0]            write_addr,
  input  logic [D_WIDTH-1:0]            write_data,
  input  logic [D_WIDTH/8-1:0]          write_be,
  output logic                          write_err,
  input  logic [RD_PORTS-1:0]           read_en,
  input  logic [RD_PORTS*A_WIDTH-1:0]   read_addr,
  output logic [RD_PORTS*D_WIDTH-1:0]   read_data,
  output logic [RD_PORTS-1:0]           read_valid,
  output logic [RD_PORTS-1:0]           read_err
);

  localparam int BE_WIDTH = D_WIDTH / 8;
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A_WIDTH:0]   DEPTH_C  = DEPTH[A_WIDTH:0];
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               init_busy_q, init_busy_d;
  logic               write_err_q, write_err_d;
  logic               clearing, ready;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [D_WIDTH-1:0] mem_wdata;

  logic [D_WIDTH-1:0] wr_mask, wr_old, wr_merged;
  logic               wr_in_range, user_wr;
  logic [IDX_W-1:0]   wr_idx;

  logic [A_WIDTH-1:0] rd_addr [RD_PORTS];
  logic [RD_PORTS-1:0] rd_ok, rd_hit, issue_v, issue_e;
  logic [D_WIDTH-1:0] issue_dat [RD_PORTS];

  logic [RD_PORTS-1:0] stg_v [RD_LATENCY];
  logic [RD_PORTS-1:0] stg_e [RD_LATENCY];
  logic [D_WIDTH-1:0]  stg_dat [RD_LATENCY][RD_PORTS];
  logic [RD_PORTS-1:0] vld_q [RD_LATENCY];
  logic [RD_PORTS-1:0] vld_d [RD_LATENCY];
  logic [RD_PORTS-1:0] err_q [RD_LATENCY];
  logic [RD_PORTS-1:0] err_d [RD_LATENCY];
  logic [D_WIDTH-1:0]  dat_q [RD_LATENCY][RD_PORTS];
  logic [D_WIDTH-1:0]  dat_d [RD_LATENCY][RD_PORTS];

  assign clearing = (state_q == ST_CLEAR);
  assign ready    = (state_q == ST_READY);

  always_comb begin : clear_fsm
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_busy_d = init_busy_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + IDX_W'(1);
      if (ptr_q == LAST_IDX) begin
        state_d     = ST_READY;
        ptr_d       = '0;
        init_busy_d = 1'b0;
      end
    end
  end

  // The clear sequencer owns the write port until the last word is zeroed.
  always_comb begin : write_path
    wr_mask = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      wr_mask[8*i +: 8] = {8{write_be[i]}};
    end
    wr_in_range = ({1'b0, write_addr} < DEPTH_C);
    wr_idx      = write_addr[IDX_W-1:0];
    wr_old      = mem_q[wr_idx];
    wr_merged   = (wr_old & ~wr_mask) | (write_data & wr_mask);
    user_wr     = ready && write_en && wr_in_range;
    write_err_d = ready && write_en && !wr_in_range;
    mem_we      = !rst && (clearing || user_wr);
    mem_widx    = clearing ? ptr_q : wr_idx;
    mem_wdata   = clearing ? '0 : wr_merged;
  end

  always_comb begin : read_issue
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_addr[p]   = read_addr[p*A_WIDTH +: A_WIDTH];
      rd_ok[p]     = ({1'b0, rd_addr[p]} < DEPTH_C);
      rd_hit[p]    = (RDW_MODE != 0) && user_wr && (rd_addr[p] == write_addr);
      issue_v[p]   = ready && read_en[p];
      issue_e[p]   = issue_v[p] && !rd_ok[p];
      issue_dat[p] = '0;
      if (rd_ok[p]) begin
        issue_dat[p] = rd_hit[p] ? wr_merged : mem_q[rd_addr[p][IDX_W-1:0]];
      end
    end
  end

  // Each stage loads data only alongside a valid, so the last stage holds its value.
  always_comb begin : read_pipe
    stg_v[0]   = issue_v;
    stg_e[0]   = issue_e;
    stg_dat[0] = issue_dat;
    for (int s = 1; s < RD_LATENCY; s++) begin
      stg_v[s]   = vld_q[s-1];
      stg_e[s]   = err_q[s-1];
      stg_dat[s] = dat_q[s-1];
    end
    for (int s = 0; s < RD_LATENCY; s++) begin
      vld_d[s] = stg_v[s];
      err_d[s] = stg_e[s] & stg_v[s];
      for (int p = 0; p < RD_PORTS; p++) begin
        dat_d[s][p] = stg_v[s][p] ? stg_dat[s][p] : dat_q[s][p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      init_busy_q <= 1'b1;
      write_err_q <= 1'b0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        vld_q[s] <= '0;
        err_q[s] <= '0;
        for (int p = 0; p < RD_PORTS; p++) begin
          dat_q[s][p] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_busy_q <= init_busy_d;
      write_err_q <= write_err_d;
      for (int s = 0; s < RD_LATENCY; s++) begin
        vld_q[s] <= vld_d[s];
        err_q[s] <= err_d[s];
        for (int p = 0; p < RD_PORTS; p++) begin
          dat_q[s][p] <= dat_d[s][p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  always_comb begin : out_pack
    for (int p = 0; p < RD_PORTS; p++) begin
      read_data[p*D_WIDTH +: D_WIDTH] = dat_q[RD_LATENCY-1][p];
    end
  end

  assign read_valid = vld_q[RD_LATENCY-1];
  assign read_err   = err_q[RD_LATENCY-1];
  assign write_err  = write_err_q;
  assign init_busy  = init_busy_q;
  assign state_dbg  = (state_q == ST_READY);

endmodule

// File: tb/tb_ram_mp_bank.sv
// Bench for ram_mp_bank: two configurations share one stimulus stream; a negedge
// monitor pops expected {cycle, err, data} entries whenever a read port is valid.
module tb_ram_mp_bank;

  localparam int EW = 49;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_be = '0;
  logic [1:0]  read_en = '0;
  logic [9:0]  read_addr = '0;

  logic        a_busy, a_state, a_werr, b_busy, b_state, b_werr;
  logic [63:0] a_rdata, b_rdata;
  logic [1:0]  a_rvalid, a_rerr, b_rvalid, b_rerr;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q [4][$];

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: full depth, latency 3, old-data read-during-write.
  ram_mp_bank #(.D_WIDTH(32), .A_WIDTH(5), .DEPTH(32), .RD_PORTS(2),
                .RD_LATENCY(3), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .init_busy(a_busy), .state_dbg(a_state),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_be(write_be), .write_err(a_werr), .read_en(read_en),
    .read_addr(read_addr), .read_data(a_rdata), .read_valid(a_rvalid),
    .read_err(a_rerr)
  );

  // Instance B: 20 words, latency 2, new-data read-during-write.
  ram_mp_bank #(.D_WIDTH(32), .A_WIDTH(5), .DEPTH(20), .RD_PORTS(2),
                .RD_LATENCY(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .init_busy(b_busy), .state_dbg(b_state),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_be(write_be), .write_err(b_werr), .read_en(read_en),
    .read_addr(read_addr), .read_data(b_rdata), .read_valid(b_rvalid),
    .read_err(b_rerr)
  );

  logic [3:0]   mon_v, mon_e;
  logic [127:0] mon_d;
  assign mon_v = {b_rvalid, a_rvalid};
  assign mon_e = {b_rerr, a_rerr};
  assign mon_d = {b_rdata, a_rdata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] want, got;
    for (int k = 0; k < 4; k++) begin
      if (mon_v[k] === 1'b1) begin
        got = {16'(cyc), mon_e[k], mon_d[k*32 +: 32]};
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_valid_inst%0d_port%0d", k / 2, k % 2), {15'd0, got}, 64'd0);
        end else begin
          want = exp_q[k].pop_front();
          check($sformatf("read_inst%0d_port%0d", k / 2, k % 2), {15'd0, got}, {15'd0, want});
        end
      end
    end
  end

  // Push expected {cycle, err, data} for one port of both instances.
  task automatic exp_rd(input int port, input logic ea, input logic [31:0] da,
                        input logic eb, input logic [31:0] db);
    exp_q[port].push_back({16'(cyc + 3), ea, da});
    exp_q[2 + port].push_back({16'(cyc + 2), eb, db});
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [1:0] re,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk); #1;
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    write_be   = be;
    read_en    = re;
    read_addr  = {ra1, ra0};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b00, 5'd0, 5'd0);
  endtask

  // Counts init_busy cycles after reset release; optionally pokes accesses meanwhile.
  task automatic wait_clear(input logic poke);
    int ca, cb;
    logic werr_seen;
    ca = 0; cb = 0; werr_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_busy === 1'b1) ca++;
      if (b_busy === 1'b1) cb++;
      if (a_werr !== 1'b0 || b_werr !== 1'b0) werr_seen = 1'b1;
      if (poke && i < 8) begin
        write_en = 1'b1; write_addr = 5'd25; write_data = 32'hFFFF_FFFF;
        write_be = 4'hF; read_en = 2'b11; read_addr = {5'd3, 5'd2};
      end else begin
        write_en = 1'b0; read_en = 2'b00;
      end
      if (a_busy === 1'b0 && b_busy === 1'b0) break;
    end
    check("busy_cycles_a", ca, 32);
    check("busy_cycles_b", cb, 20);
    check("werr_during_clear", werr_seen, 1'b0);
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state and clear sequence.
    @(posedge clk);
    @(negedge clk);
    check("reset_busy", {a_busy, b_busy}, 2'b11);
    check("reset_flags", {a_rvalid, b_rvalid, a_rerr, b_rerr, a_werr, b_werr}, 10'd0);
    check("reset_data", |{a_rdata, b_rdata}, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear(1'b1);
    check("state_ready", {a_state, b_state}, 2'b11);

    // Cleared contents, plus out-of-range read on B only.
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b11, 5'd0, 5'd15);
    exp_rd(0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_rd(1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b11, 5'd31, 5'd19);
    exp_rd(0, 1'b0, 32'h0, 1'b1, 32'h0);
    exp_rd(1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);

    // Latency and back-to-back throughput.
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF, 2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b01, 5'd7, 5'd0);
      exp_rd(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    end
    idle(5);
    @(negedge clk);
    check("hold_a_port0", a_rdata[31:0], 32'hDEAD_BEEF);
    check("hold_b_port0", b_rdata[31:0], 32'hDEAD_BEEF);
    check("hold_a_port1", a_rdata[63:32], 32'h0);

    // Byte enables, including a be=0 write alongside a read.
    drive(1'b1, 5'd3, 32'h1122_3344, 4'b1111, 2'b00, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'hAABB_CCDD, 4'b0101, 2'b00, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 4'b0000, 2'b01, 5'd3, 5'd0);
    exp_rd(0, 1'b0, 32'h11BB_33DD, 1'b0, 32'h11BB_33DD);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b10, 5'd0, 5'd3);
    exp_rd(1, 1'b0, 32'h11BB_33DD, 1'b0, 32'h11BB_33DD);

    // Read-during-write, full and partial lanes.
    drive(1'b1, 5'd5, 32'h1234_5678, 4'b1111, 2'b10, 5'd0, 5'd5);
    exp_rd(1, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
    drive(1'b1, 5'd6, 32'hAABB_CCDD, 4'b0011, 2'b11, 5'd5, 5'd6);
    exp_rd(0, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678);
    exp_rd(1, 1'b0, 32'h0, 1'b0, 32'h0000_CCDD);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b10, 5'd0, 5'd6);
    exp_rd(1, 1'b0, 32'h0000_CCDD, 1'b0, 32'h0000_CCDD);

    // Range checks: address 25 is in range for A, out of range for B.
    drive(1'b1, 5'd25, 32'hFFFF_FFFF, 4'hF, 2'b00, 5'd0, 5'd0);
    idle(1);
    @(negedge clk);
    check("werr_pulse", {a_werr, b_werr}, 2'b01);
    @(negedge clk);
    check("werr_one_cycle", {a_werr, b_werr}, 2'b00);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b11, 5'd20, 5'd25);
    exp_rd(0, 1'b0, 32'h0, 1'b1, 32'h0);
    exp_rd(1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b01, 5'd5, 5'd0);
    exp_rd(0, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678);
    idle(6);

    // Reset with reads in flight: no valids, array cleared again.
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b11, 5'd7, 5'd3);
    @(posedge clk); #1;
    read_en = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear(1'b0);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b11, 5'd7, 5'd25);
    exp_rd(0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_rd(1, 1'b0, 32'h0, 1'b1, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 2'b11, 5'd3, 5'd5);
    exp_rd(0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_rd(1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(6);

    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drained_inst%0d_port%0d", k / 2, k % 2), exp_q[k].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
